// File: rtl/rv_alu_pkg.sv
// Shared ALU encodings and default datapath widths for the ID/EX operand stage.
package rv_alu_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  localparam logic [2:0] ALUOP_R      = 3'b000;
  localparam logic [2:0] ALUOP_RALT   = 3'b001;  // sub / sra variants
  localparam logic [2:0] ALUOP_BRANCH = 3'b010;
  localparam logic [2:0] ALUOP_IMM    = 3'b011;
  localparam logic [2:0] ALUOP_STORE  = 3'b101;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_ctrl_e;

endpackage

// File: rtl/fwd_select.sv
// Priority forwarding mux: EX/MEM beats MEM/WB beats the default value; x0 never forwards.
module fwd_select #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] rs_addr,
  input  logic [XLEN-1:0] rs_data,
  input  logic            mem_valid,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_valid,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] value
);

  logic addr_nz;
  assign addr_nz = |rs_addr;

  always_comb begin
    value = rs_data;
    if (mem_valid && (mem_rd == rs_addr) && addr_nz) begin
      value = mem_data;
    end else if (wb_valid && (wb_rd == rs_addr) && addr_nz) begin
      value = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with valid/ready handshake, operand forwarding at capture
// and during stalls, and flush on branch redirect.
module id_ex_operand_stage
  import rv_alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RA_W = RA_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [RA_W-1:0] in_rs1_addr,
  input  logic [RA_W-1:0] in_rs2_addr,
  input  logic [RA_W-1:0] in_rd_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_pc,
  input  logic            in_a_sel,
  input  logic            in_b_sel,
  input  logic [2:0]      in_alu_control,
  input  logic [2:0]      in_alu_op,
  input  logic            in_reg_write,
  input  logic            flush,
  input  logic            fwd_mem_valid,
  input  logic [RA_W-1:0] fwd_mem_rd,
  input  logic [XLEN-1:0] fwd_mem_data,
  input  logic            fwd_wb_valid,
  input  logic [RA_W-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0] fwd_wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [2:0]      ALUControl,
  output logic [2:0]      ALUop,
  output logic [RA_W-1:0] out_rd_addr,
  output logic            out_reg_write,
  output logic [XLEN-1:0] out_store_data
);

  logic            valid_q, valid_d;
  logic [RA_W-1:0] rs1_addr_q, rs1_addr_d;
  logic [RA_W-1:0] rs2_addr_q, rs2_addr_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] imm_q, imm_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            a_sel_q, a_sel_d;
  logic            b_sel_q, b_sel_d;
  logic [2:0]      alu_control_q, alu_control_d;
  logic [2:0]      alu_op_q, alu_op_d;
  logic            reg_write_q, reg_write_d;

  logic capture;
  logic stall;

  // Index 0 is rs1, index 1 is rs2, for both the capture and refresh paths.
  logic [RA_W-1:0] cap_addr [2];
  logic [XLEN-1:0] cap_data [2];
  logic [XLEN-1:0] cap_fwd  [2];
  logic [XLEN-1:0] cap_val  [2];
  logic [RA_W-1:0] hold_addr [2];
  logic [XLEN-1:0] hold_data [2];
  logic [XLEN-1:0] hold_fwd  [2];

  assign in_ready = !valid_q || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign stall    = valid_q && !out_ready && !flush;

  assign cap_addr[0]  = in_rs1_addr;
  assign cap_addr[1]  = in_rs2_addr;
  assign cap_data[0]  = in_rs1_data;
  assign cap_data[1]  = in_rs2_data;
  assign hold_addr[0] = rs1_addr_q;
  assign hold_addr[1] = rs2_addr_q;
  assign hold_data[0] = rs1_q;
  assign hold_data[1] = rs2_q;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      fwd_select #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_cap (
        .rs_addr   (cap_addr[gi]),
        .rs_data   (cap_data[gi]),
        .mem_valid (fwd_mem_valid),
        .mem_rd    (fwd_mem_rd),
        .mem_data  (fwd_mem_data),
        .wb_valid  (fwd_wb_valid),
        .wb_rd     (fwd_wb_rd),
        .wb_data   (fwd_wb_data),
        .value     (cap_fwd[gi])
      );

      fwd_select #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_hold (
        .rs_addr   (hold_addr[gi]),
        .rs_data   (hold_data[gi]),
        .mem_valid (fwd_mem_valid),
        .mem_rd    (fwd_mem_rd),
        .mem_data  (fwd_mem_data),
        .wb_valid  (fwd_wb_valid),
        .wb_rd     (fwd_wb_rd),
        .wb_data   (fwd_wb_data),
        .value     (hold_fwd[gi])
      );

      // x0 reads as zero regardless of what the register file returned.
      assign cap_val[gi] = (|cap_addr[gi]) ? cap_fwd[gi] : '0;
    end
  endgenerate

  always_comb begin
    valid_d       = valid_q;
    rs1_addr_d    = rs1_addr_q;
    rs2_addr_d    = rs2_addr_q;
    rd_d          = rd_q;
    rs1_d         = rs1_q;
    rs2_d         = rs2_q;
    imm_d         = imm_q;
    pc_d          = pc_q;
    a_sel_d       = a_sel_q;
    b_sel_d       = b_sel_q;
    alu_control_d = alu_control_q;
    alu_op_d      = alu_op_q;
    reg_write_d   = reg_write_q;

    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d       = 1'b1;
      rs1_addr_d    = in_rs1_addr;
      rs2_addr_d    = in_rs2_addr;
      rd_d          = in_rd_addr;
      rs1_d         = cap_val[0];
      rs2_d         = cap_val[1];
      imm_d         = in_imm;
      pc_d          = in_pc;
      a_sel_d       = in_a_sel;
      b_sel_d       = in_b_sel;
      alu_control_d = in_alu_control;
      alu_op_d      = in_alu_op;
      reg_write_d   = in_reg_write;
    end else if (stall) begin
      rs1_d = hold_fwd[0];
      rs2_d = hold_fwd[1];
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      rs1_addr_q    <= '0;
      rs2_addr_q    <= '0;
      rd_q          <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      imm_q         <= '0;
      pc_q          <= '0;
      a_sel_q       <= 1'b0;
      b_sel_q       <= 1'b0;
      alu_control_q <= '0;
      alu_op_q      <= '0;
      reg_write_q   <= 1'b0;
    end else begin
      valid_q       <= valid_d;
      rs1_addr_q    <= rs1_addr_d;
      rs2_addr_q    <= rs2_addr_d;
      rd_q          <= rd_d;
      rs1_q         <= rs1_d;
      rs2_q         <= rs2_d;
      imm_q         <= imm_d;
      pc_q          <= pc_d;
      a_sel_q       <= a_sel_d;
      b_sel_q       <= b_sel_d;
      alu_control_q <= alu_control_d;
      alu_op_q      <= alu_op_d;
      reg_write_q   <= reg_write_d;
    end
  end

  assign out_valid      = valid_q;
  assign SrcA           = a_sel_q ? pc_q : rs1_q;
  assign SrcB           = b_sel_q ? imm_q : rs2_q;
  assign out_store_data = rs2_q;
  assign ALUControl     = alu_control_q;
  assign ALUop          = alu_op_q;
  assign out_rd_addr    = rd_q;
  assign out_reg_write  = reg_write_q && valid_q;

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register and operand-selection stage. It sits directly upstream of the ALU and produces SrcA, SrcB, ALUControl and ALUop.
- Captures decoded instruction fields under a valid/ready handshake and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB buses.
- Keeps held operands current while stalled and supports flush on branch redirect.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decoder offers an instruction
- in_ready  out  1  stage can accept this cycle
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  RA_W each  register indices
- in_rs1_data, in_rs2_data  in  XLEN each  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_pc  in  XLEN  instruction PC
- in_a_sel  in  1  0: SrcA=rs1, 1: SrcA=pc
- in_b_sel  in  1  0: SrcB=rs2, 1: SrcB=imm
- in_alu_control  in  3  funct3-style ALU select
- in_alu_op  in  3  ALU operation class
- in_reg_write  in  1  instruction writes rd
- flush  in  1  kill held and incoming instruction
- fwd_mem_valid  in  1  EX/MEM forwarding bus valid
- fwd_mem_rd  in  RA_W  EX/MEM forwarding destination
- fwd_mem_data  in  XLEN  EX/MEM forwarding data
- fwd_wb_valid  in  1  MEM/WB forwarding bus valid
- fwd_wb_rd  in  RA_W  MEM/WB forwarding destination
- fwd_wb_data  in  XLEN  MEM/WB forwarding data
- out_valid  out  1  held instruction valid
- out_ready  in  1  ALU/EX consumer accepts
- SrcA, SrcB  out  XLEN each  ALU operands
- ALUControl, ALUop  out  3 each  ALU controls
- out_rd_addr  out  RA_W  destination register
- out_reg_write  out  1  destination write enable (gated by out_valid)
- out_store_data  out  XLEN  forwarded rs2 value for stores

Behaviour:
- Reset (rst_n low, async): out_valid=0, all held fields and outputs 0. On release the first capture is possible on the first clk edge.
- in_ready = !out_valid || out_ready. Combinational; no combinational in_valid->in_ready path.
- Capture: in_valid && in_ready && !flush loads all fields next edge and sets out_valid=1. Latency is 1 cycle from capture to outputs.
- Consume without new capture: out_valid && out_ready && !(in_valid && in_ready) sets out_valid=0.
- Back-to-back: consume and capture in the same cycle replace the contents, and out_valid stays 1. Full throughput is 1 instruction/cycle.
- Flush has top priority. The next edge gives out_valid=0 and discards any simultaneous capture. Held fields may keep stale data but out_reg_write must read 0.
- Forwarding at capture:
  - Operand value = fwd_mem_data if fwd_mem_valid && fwd_mem_rd==rs_addr && rs_addr!=0.
  - Else fwd_wb_data if the same condition holds on the WB bus.
  - Else in_rsN_data.
  - MEM outranks WB.
- Forwarding while stalled (out_valid && !out_ready): each edge re-applies the same rule to the held rs1/rs2 values using the held addresses. This keeps results completing during a stall visible.
- x0: rs address 0 is never forwarded, and the held value is forced to 0 at capture.
- Outputs:
  - SrcA = a_sel_q ? pc_q : rs1_q.
  - SrcB = b_sel_q ? imm_q : rs2_q.
  - out_store_data = rs2_q.
  - Outputs are combinational from held registers only; there is no path from forwarding inputs to outputs within the same cycle.
- out_reg_write = reg_write_q && out_valid.
- ALUControl/ALUop pass through unmodified. No arithmetic in this block; all widths are exact.

Decomposition:
- Shared package rv_alu_pkg:
  - ALUOP_R=3'b000, ALUOP_RALT=3'b001 (sub/sra), ALUOP_BRANCH=3'b010, ALUOP_IMM=3'b011, ALUOP_STORE=3'b101.
  - ALUControl codes ADD=000, SLL=001, SLT=010, SLTU=011, XOR=100, SRL=101, OR=110, AND=111.
  - XLEN and RA_W defaults.
- Sub-module fwd_select: combinational priority mux (addr, default data, two forwarding buses -> value). Instantiated twice for capture and twice for stall refresh.

Test Plan:
- Reset then capture: rs1=5/data 0x10, rs2=6/data 0x20, b_sel=0, out_ready=1 -> next cycle out_valid=1, SrcA=0x10, SrcB=0x20.
- Capture forwarding with MEM and WB both matching rs1=5: mem_data=0xAA, wb_data=0xBB -> SrcA=0xAA. Same stimulus with rs1=0 -> SrcA=0.
- Stall refresh: hold with out_ready=0, rs2=7 held at 0x1, then pulse fwd_wb_valid, rd=7, data=0x55 -> next cycle SrcB=0x55 and out_store_data=0x55; in_ready=0 throughout.
- Flush priority: out_valid=1, in_valid=1, flush=1 in the same cycle -> next cycle out_valid=0, out_reg_write=0, the new instruction is not captured, and in_ready=1.
- Streaming: 8 instructions with in_valid and out_ready held at 1 -> 8 consecutive out_valid cycles in order, with no bubbles.
- Async reset mid-stall: assert rst_n=0 between edges while out_valid=1 -> out_valid=0 and SrcA/SrcB=0 immediately, without waiting for clk.
